// File: rtl/timer_set_pkg.sv
// Shared encodings and constants for the timer-set datapath.
// Display selects, BCD limits, keypad digit range and the field clamp helper.
package timer_set_pkg;

  typedef enum logic [1:0] {
    DSEL_RUN   = 2'd0,
    DSEL_ENTRY = 2'd1,
    DSEL_KEYS  = 2'd2,
    DSEL_OFF   = 2'd3
  } dsel_e;

  localparam logic [7:0] BCD_MAX_SS    = 8'h59;
  localparam logic [7:0] BLANK_FIELD   = 8'hFF;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'd9;

  // A field with an out-of-range tens or units digit saturates to 59.
  function automatic logic [7:0] bcd_clamp(input logic [7:0] f);
    return ((f[7:4] > 4'd5) || (f[3:0] > 4'd9)) ? BCD_MAX_SS : f;
  endfunction

endpackage

// File: rtl/timer_set_datapath_if.sv
// Control word, keypad/tick inputs and status/display outputs of the timer-set datapath.
// master = controller/stimulus side, slave = datapath side.
interface timer_set_datapath_if;

  logic [3:0]  key_val;
  logic        key_strobe;
  logic        tick_1hz;
  logic        La;
  logic        Lb;
  logic        Lr;
  logic        Ea;
  logic        Er;
  logic        Kc;
  logic [1:0]  s;
  logic        t;
  logic        k7;
  logic        run;
  logic [15:0] disp;

  modport master (
    output key_val, key_strobe, tick_1hz, La, Lb, Lr, Ea, Er, Kc, s,
    input  t, k7, run, disp
  );

  modport slave (
    input  key_val, key_strobe, tick_1hz, La, Lb, Lr, Ea, Er, Kc, s,
    output t, k7, run, disp
  );

endinterface

// File: rtl/timer_set_datapath_bcd_mod60_down.sv
// Two-digit BCD decrement modulo 60: 00 wraps to 59 and raises borrow_o.
// Purely combinational; input is assumed to be a valid BCD value <= 59.
module bcd_mod60_down
  import timer_set_pkg::*;
(
  input  logic [7:0] val_i,
  output logic [7:0] dec_o,
  output logic       borrow_o
);

  always_comb begin
    dec_o    = val_i;
    borrow_o = 1'b0;
    if (val_i == 8'h00) begin
      dec_o    = BCD_MAX_SS;
      borrow_o = 1'b1;
    end else if (val_i[3:0] == 4'd0) begin
      dec_o = {val_i[7:4] - 4'd1, 4'd9};
    end else begin
      dec_o = {val_i[7:4], val_i[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/timer_set_datapath.sv
// Timer-set datapath: keypad entry registers, BCD mm:ss countdown, status flags, display mux.
// All outputs registered (1 cycle); no backpressure. Optional blink of the edited field: TSET_BLINK_EN.
module timer_set_datapath
  import timer_set_pkg::*;
#(
  parameter int MAX_KEYS  = 7,
  parameter int BLINK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  timer_set_datapath_if.slave  bus
);

  localparam int KCW = $clog2(MAX_KEYS + 1);

  logic [7:0]     a_q, a_d, b_q, b_d;
  logic [KCW-1:0] kcnt_q, kcnt_d;
  logic           k7_q, k7_d;
  logic [15:0]    r_q, r_d;
  logic           run_q, run_d;
  logic           t_q, t_d;
  logic [15:0]    disp_q, disp_d;

  logic           digit_ok;
  logic [7:0]     ss_dec, mm_dec;
  logic           ss_borrow, mm_borrow_unused;
  logic [15:0]    r_dec, load_val;
  logic           count_en;
  logic [15:0]    entry_view;

  assign digit_ok = bus.key_strobe && (bus.key_val <= KEY_DIGIT_MAX) && (bus.La || bus.Lb);

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    kcnt_d = kcnt_q;
    if (digit_ok) begin
      if (bus.La) a_d = {a_q[3:0], bus.key_val};
      else        b_d = {b_q[3:0], bus.key_val};
      if (kcnt_q != KCW'(MAX_KEYS)) kcnt_d = kcnt_q + KCW'(1);
    end
    if (bus.Kc) kcnt_d = '0;
    k7_d = (kcnt_d == KCW'(MAX_KEYS));
  end

  bcd_mod60_down u_ss (
    .val_i    (r_q[7:0]),
    .dec_o    (ss_dec),
    .borrow_o (ss_borrow)
  );

  // Minutes never wrap below 00 because R==0 blocks the decrement.
  bcd_mod60_down u_mm (
    .val_i    (r_q[15:8]),
    .dec_o    (mm_dec),
    .borrow_o (mm_borrow_unused)
  );

  assign r_dec    = {ss_borrow ? mm_dec : r_q[15:8], ss_dec};
  assign load_val = {bcd_clamp(b_q), bcd_clamp(a_q)};
  assign count_en = bus.tick_1hz && bus.Ea && run_q && (r_q != 16'h0000);

  always_comb begin
    r_d   = r_q;
    run_d = run_q;
    t_d   = t_q;
    if (bus.Er) begin
      r_d   = 16'h0000;
      run_d = 1'b0;
      t_d   = 1'b0;
    end else if (bus.Lr) begin
      r_d   = load_val;
      run_d = (load_val != 16'h0000);
      t_d   = (load_val == 16'h0000);
    end else if (count_en) begin
      r_d = r_dec;
      if (r_dec == 16'h0000) begin
        run_d = 1'b0;
        t_d   = 1'b1;
      end
    end
  end

`ifdef TSET_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (bus.tick_1hz) begin
      if (bcnt_q == BW'(BLINK_DIV - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    entry_view = {b_q, a_q};
    if (phase_q) begin
      if (bus.La)      entry_view[7:0]  = BLANK_FIELD;
      else if (bus.Lb) entry_view[15:8] = BLANK_FIELD;
    end
  end
`else
  localparam int blink_div_unused = BLINK_DIV;

  assign entry_view = {b_q, a_q};
`endif

  always_comb begin
    disp_d = 16'h0000;
    case (dsel_e'(bus.s))
      DSEL_RUN:   disp_d = r_q;
      DSEL_ENTRY: disp_d = entry_view;
      DSEL_KEYS:  disp_d = 16'(kcnt_q);
      DSEL_OFF:   disp_d = 16'h0000;
      default:    disp_d = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      kcnt_q <= '0;
      k7_q   <= 1'b0;
      r_q    <= 16'h0000;
      run_q  <= 1'b0;
      t_q    <= 1'b0;
      disp_q <= 16'h0000;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      kcnt_q <= kcnt_d;
      k7_q   <= k7_d;
      r_q    <= r_d;
      run_q  <= run_d;
      t_q    <= t_d;
      disp_q <= disp_d;
    end
  end

  assign bus.t    = t_q;
  assign bus.k7   = k7_q;
  assign bus.run  = run_q;
  assign bus.disp = disp_q;

endmodule

// File: tb/tb_timer_set_datapath.sv
// Bench for timer_set_datapath: directed test-plan sequences plus random control words,
// checked each cycle by a scoreboard fed from a seconds/digit-level reference model.
module tb_timer_set_datapath;

  localparam int MAX_KEYS  = 7;
  localparam int BLINK_DIV = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  timer_set_datapath_if bus ();

  timer_set_datapath #(
    .MAX_KEYS  (MAX_KEYS),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic        t;
    logic        k7;
    logic        run;
    logic [15:0] disp;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: entry digits as integers, timer as a plain count of seconds.
  int          a_t, a_u, b_t, b_u, cnt, secs, ticks, ph, mm, ss;
  bit          m_run, m_t, m_k7;
  logic [15:0] m_disp;
  logic [7:0]  fa, fb;

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_field(input int tn, input int un);
    return ((tn > 5) || (un > 9)) ? 59 : tn * 10 + un;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_t = 0; a_u = 0; b_t = 0; b_u = 0;
      cnt = 0; secs = 0; ticks = 0;
      m_run = 0; m_t = 0; m_k7 = 0; m_disp = 16'h0000;
      if (clk) exp_q.push_back(obs_t'{1'b0, 1'b0, 1'b0, 16'h0000});
    end else begin
`ifdef TSET_BLINK_EN
      ph = (ticks / BLINK_DIV) % 2;
`else
      ph = 0;
`endif
      fa = {4'(a_t), 4'(a_u)};
      fb = {4'(b_t), 4'(b_u)};
      if (bus.s == 2'd1 && ph == 1) begin
        if (bus.La)      fa = 8'hFF;
        else if (bus.Lb) fb = 8'hFF;
      end
      case (bus.s)
        2'd0:    m_disp = {bcd2(secs / 60), bcd2(secs % 60)};
        2'd1:    m_disp = {fb, fa};
        2'd2:    m_disp = 16'(cnt);
        default: m_disp = 16'h0000;
      endcase
      if (bus.Er) begin
        secs = 0; m_run = 0; m_t = 0;
      end else if (bus.Lr) begin
        mm   = clamp_field(b_t, b_u);
        ss   = clamp_field(a_t, a_u);
        secs = mm * 60 + ss;
        m_run = (secs != 0);
        m_t   = (secs == 0);
      end else if (bus.tick_1hz && bus.Ea && m_run && secs != 0) begin
        secs = secs - 1;
        if (secs == 0) begin
          m_run = 0; m_t = 1;
        end
      end
      if (bus.key_strobe && bus.key_val <= 4'd9 && (bus.La || bus.Lb)) begin
        if (bus.La) begin
          a_t = a_u; a_u = int'(bus.key_val);
        end else begin
          b_t = b_u; b_u = int'(bus.key_val);
        end
        if (cnt < MAX_KEYS) cnt = cnt + 1;
      end
      if (bus.Kc) cnt = 0;
      m_k7 = (cnt == MAX_KEYS);
      if (bus.tick_1hz) ticks = ticks + 1;
      exp_q.push_back(obs_t'{m_t, m_k7, m_run, m_disp});
    end
  end

  logic last_rst = 1'b0;
  bit   started  = 0;

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n && last_rst) begin
      #1;
      n_cmp++;
      if ({bus.t, bus.k7, bus.run, bus.disp} !== 19'h0) begin
        n_bad++;
        $display("FAIL async_reset @%0t: got t=%b k7=%b run=%b disp=%h, want all zero",
                 $time, bus.t, bus.k7, bus.run, bus.disp);
      end
    end else if (!clk) begin
      if (exp_q.size() == 0) begin
        if (started) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty @%0t: no expected entry queued", $time);
        end
      end else begin
        obs_t e, g;
        e = exp_q.pop_front();
        g = '{bus.t, bus.k7, bus.run, bus.disp};
        started = 1;
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL scoreboard @%0t: got t=%b k7=%b run=%b disp=%h, want t=%b k7=%b run=%b disp=%h",
                   $time, g.t, g.k7, g.run, g.disp, e.t, e.k7, e.run, e.disp);
        end
      end
    end
    last_rst = rst_n;
  end

  task automatic clr();
    bus.key_strobe = 1'b0;
    bus.La = 1'b0; bus.Lb = 1'b0; bus.Lr = 1'b0;
    bus.Er = 1'b0; bus.Kc = 1'b0; bus.tick_1hz = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clr();
    end
  endtask

  task automatic key(input bit to_a, input logic [3:0] v);
    @(negedge clk);
    clr();
    bus.key_val    = v;
    bus.key_strobe = 1'b1;
    if (to_a) bus.La = 1'b1;
    else      bus.Lb = 1'b1;
  endtask

  task automatic ctl(input bit lr, input bit tk, input bit er, input bit kc);
    @(negedge clk);
    clr();
    bus.Lr = lr; bus.tick_1hz = tk; bus.Er = er; bus.Kc = kc;
  endtask

  initial begin
    clr();
    bus.key_val = 4'd0;
    bus.Ea      = 1'b0;
    bus.s       = 2'd0;
    idle(3);
    #2 rst_n = 1'b1;
    idle(1);

    // Entry: A=12, B=03, four keys counted.
    bus.s = 2'd1;
    key(1, 4'd1); key(1, 4'd2); key(0, 4'd0); key(0, 4'd3);
    idle(2);
    bus.s = 2'd2;
    idle(2);

    // Saturation at MAX_KEYS, ignored code, then clear.
    ctl(0, 0, 0, 1);
    for (int i = 0; i < 7; i++) key(1, 4'(i + 1));
    key(0, 4'hB);
    idle(2);
    bus.s = 2'd1;
    idle(1);
    ctl(0, 0, 0, 1);
    idle(2);

    // 01:00 countdown through expiry and one extra tick.
    bus.s = 2'd0;
    key(0, 4'd0); key(0, 4'd1); key(1, 4'd0); key(1, 4'd0);
    bus.Ea = 1'b1;
    ctl(1, 0, 0, 0);
    ctl(0, 1, 0, 0);
    repeat (59) begin
      ctl(0, 1, 0, 0);
      idle(1);
    end
    ctl(0, 1, 0, 0);
    idle(2);

    // Clamping of both fields, then zero load.
    key(1, 4'd7); key(1, 4'd5); key(0, 4'd9); key(0, 4'd9);
    ctl(1, 0, 0, 0);
    idle(2);
    key(1, 4'd0); key(1, 4'd0); key(0, 4'd0); key(0, 4'd0);
    ctl(1, 0, 0, 0);
    idle(2);

    // Er beats Lr and tick in the same cycle.
    key(0, 4'd0); key(0, 4'd2);
    ctl(1, 0, 0, 0);
    ctl(0, 1, 0, 0);
    ctl(1, 1, 1, 0);
    idle(2);

    // Asynchronous reset in the middle of a countdown.
    ctl(1, 0, 0, 0);
    repeat (3) ctl(0, 1, 0, 0);
    idle(1);
    #3 rst_n = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    ctl(0, 1, 0, 0);
    idle(2);

    // Edited field with ticks while showing the entry.
    bus.s = 2'd1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clr();
      bus.La       = 1'b1;
      bus.tick_1hz = (i % 2 == 0);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      clr();
      bus.Lb       = 1'b1;
      bus.tick_1hz = (i % 2 == 0);
    end
    idle(2);

    // Random control words.
    repeat (2500) begin
      @(negedge clk);
      bus.key_val    = 4'($urandom_range(0, 15));
      bus.key_strobe = ($urandom_range(0, 2) == 0);
      bus.La         = ($urandom_range(0, 3) == 0);
      bus.Lb         = ($urandom_range(0, 3) == 0);
      bus.tick_1hz   = ($urandom_range(0, 2) == 0);
      bus.Ea         = ($urandom_range(0, 3) != 0);
      bus.Lr         = ($urandom_range(0, 29) == 0);
      bus.Er         = ($urandom_range(0, 79) == 0);
      bus.Kc         = ($urandom_range(0, 19) == 0);
      bus.s          = 2'($urandom_range(0, 3));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
